// File: rtl/wr_dma_pkg.sv
// wr_dma_pkg: shared FSM state encoding, page size and beats-to-page-end helper
package wr_dma_pkg;
  typedef enum logic [4:0] {
    IDLE = 5'b00001,
    CALC = 5'b00010,
    WAIT = 5'b00100,
    DATA = 5'b01000,
    NEXT = 5'b10000
  } state_t;
  localparam int PAGE_BYTES = 4096;
  function automatic int beats_to_page(input logic [11:0] addr, input int bytes);
    return (PAGE_BYTES - int'(addr)) / bytes;
  endfunction
endpackage

// File: rtl/wr_burst_calc.sv
// wr_burst_calc: registers burst_beats = min(remain, MAX_BURST_LEN, beats left in the 4 KB page) when en
module wr_burst_calc
  import wr_dma_pkg::*;
#(
  parameter int AXI_DATA_WIDTH = 128,
  parameter int MAX_BURST_LEN  = 64,
  parameter int LEN_WIDTH      = 16
) (
  input  logic                 wr_clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [11:0]          page_off,
  input  logic [LEN_WIDTH-1:0] remain,
  output logic [8:0]           burst_beats
);
  localparam int BYTES = AXI_DATA_WIDTH / 8;
  int room, lim, nxt;
  always_comb begin
    room = beats_to_page(page_off, BYTES);
    lim  = MAX_BURST_LEN < room ? MAX_BURST_LEN : room;
    nxt  = int'(remain) < lim ? int'(remain) : lim;
  end
  always_ff @(posedge wr_clk)
    if (rst) burst_beats <= '0;
    else if (en) burst_beats <= 9'(nxt);
endmodule

// File: rtl/wr_burst_ctrl.sv
// wr_burst_ctrl: splits DMA write commands into page-safe bursts of at most MAX_BURST_LEN beats and streams their data
module wr_burst_ctrl
  import wr_dma_pkg::*;
#(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 128,
  parameter int MAX_BURST_LEN  = 64,
  parameter int LEN_WIDTH      = 16
) (
  input  logic                      wr_clk,
  input  logic                      rst,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [AXI_ADDR_WIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]      cmd_beats,
  input  logic [AXI_DATA_WIDTH-1:0] s_data,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic                      buf_afull,
  output logic                      wr_req_en,
  output logic [AXI_ADDR_WIDTH-1:0] wr_addr_in,
  output logic [7:0]                wr_burst_len,
  output logic [AXI_DATA_WIDTH-1:0] wr_data_in,
  output logic                      wr_data_valid,
  output logic                      wr_data_last,
  output logic                      busy,
  output logic                      cmd_done,
  output logic                      err_zero_len
);
  localparam int LB = $clog2(AXI_DATA_WIDTH / 8);
  localparam logic [AXI_ADDR_WIDTH-1:0] AMASK = ~AXI_ADDR_WIDTH'(AXI_DATA_WIDTH / 8 - 1);
  state_t state;
  logic [AXI_ADDR_WIDTH-1:0] cur_addr;
  logic [LEN_WIDTH-1:0] remain;
  logic [8:0] burst_beats, beat_cnt;
  logic last_beat;
  assign cmd_ready = state == IDLE && !rst;
  assign s_ready   = state == DATA && !rst;
  assign busy      = state != IDLE;
  assign last_beat = beat_cnt == burst_beats - 9'd1;
  wr_burst_calc #(
    .AXI_DATA_WIDTH(AXI_DATA_WIDTH),
    .MAX_BURST_LEN (MAX_BURST_LEN),
    .LEN_WIDTH     (LEN_WIDTH)
  ) u_calc (
    .wr_clk     (wr_clk),
    .rst        (rst),
    .en         (state == CALC),
    .page_off   (cur_addr[11:0]),
    .remain     (remain),
    .burst_beats(burst_beats)
  );
  always_ff @(posedge wr_clk)
    if (rst) begin
      state         <= IDLE;
      cur_addr      <= '0;
      remain        <= '0;
      beat_cnt      <= '0;
      wr_req_en     <= 1'b0;
      wr_addr_in    <= '0;
      wr_burst_len  <= '0;
      wr_data_in    <= '0;
      wr_data_valid <= 1'b0;
      wr_data_last  <= 1'b0;
      cmd_done      <= 1'b0;
      err_zero_len  <= 1'b0;
    end else begin
      wr_req_en     <= 1'b0;
      wr_data_valid <= 1'b0;
      wr_data_last  <= 1'b0;
      cmd_done      <= 1'b0;
      err_zero_len  <= 1'b0;
      case (state)
        IDLE: if (cmd_valid) begin
          cur_addr <= cmd_addr & AMASK;
          remain   <= cmd_beats;
          if (cmd_beats == '0) err_zero_len <= 1'b1;
          else state <= CALC;
        end
        CALC: state <= WAIT;
        WAIT: if (!buf_afull) begin
          wr_req_en    <= 1'b1;
          wr_addr_in   <= cur_addr;
          wr_burst_len <= 8'(burst_beats - 9'd1);
          beat_cnt     <= '0;
          state        <= DATA;
        end
        DATA: if (s_valid) begin
          wr_data_valid <= 1'b1;
          wr_data_in    <= s_data;
          wr_data_last  <= last_beat;
          beat_cnt      <= beat_cnt + 9'd1;
          if (last_beat) state <= NEXT;
        end
        NEXT: begin
          cur_addr <= cur_addr + (AXI_ADDR_WIDTH'(burst_beats) << LB);
          remain   <= remain - LEN_WIDTH'(burst_beats);
          if (remain == LEN_WIDTH'(burst_beats)) begin
            cmd_done <= 1'b1;
            state    <= IDLE;
          end else state <= CALC;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_wr_burst_ctrl.sv
// tb_wr_burst_ctrl: randomized self-checking bench with a burst-splitting reference model and data scoreboard
module tb_wr_burst_ctrl;
  localparam int AW = 32, DW = 128, MAXB = 64, LW = 16, BYTES = DW / 8;
  logic wr_clk = 1'b0, rst = 1'b1, cmd_valid = 1'b0, s_valid = 1'b0, buf_afull = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [LW-1:0] cmd_beats = '0;
  logic [DW-1:0] s_data = '0;
  logic cmd_ready, s_ready, wr_req_en, wr_data_valid, wr_data_last, busy, cmd_done, err_zero_len;
  logic [AW-1:0] wr_addr_in;
  logic [7:0] wr_burst_len;
  logic [DW-1:0] wr_data_in;
  int n_cmp = 0, n_err = 0;
  logic [AW-1:0] exp_addr[$];
  int exp_len[$];
  logic [DW-1:0] exp_data[$];
  logic [DW-1:0] src_q[$];
  int src_idx = 0, src_pct = 100, left = 0, data_seen = 0, req_cnt = 0, done_cnt = 0, err_cnt = 0, exp_done = 0;
  bit afull_rand = 1'b0, afull_force = 1'b0, hs = 1'b0;
  wr_burst_ctrl #(
    .AXI_ADDR_WIDTH(AW),
    .AXI_DATA_WIDTH(DW),
    .MAX_BURST_LEN (MAXB),
    .LEN_WIDTH     (LW)
  ) dut (
    .wr_clk       (wr_clk),
    .rst          (rst),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_addr     (cmd_addr),
    .cmd_beats    (cmd_beats),
    .s_data       (s_data),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .buf_afull    (buf_afull),
    .wr_req_en    (wr_req_en),
    .wr_addr_in   (wr_addr_in),
    .wr_burst_len (wr_burst_len),
    .wr_data_in   (wr_data_in),
    .wr_data_valid(wr_data_valid),
    .wr_data_last (wr_data_last),
    .busy         (busy),
    .cmd_done     (cmd_done),
    .err_zero_len (err_zero_len)
  );
  always #5 wr_clk = ~wr_clk;
  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  initial forever begin
    @(negedge wr_clk);
    #1;
    if (hs) src_idx++;
    s_valid = src_idx < src_q.size() && $urandom_range(1, 100) <= src_pct;
    s_data = s_valid ? src_q[src_idx] : {$urandom, $urandom, $urandom, $urandom};
    buf_afull = afull_rand ? $urandom_range(0, 3) == 0 : afull_force;
    hs = s_valid && s_ready;
  end
  initial forever begin
    @(negedge wr_clk);
    check("last_needs_valid", wr_data_last & ~wr_data_valid, 1'b0);
    if (wr_data_valid) begin
      data_seen++;
      check("data_in_burst", left > 0, 1'b1);
      check("data_expected", exp_data.size() > 0, 1'b1);
      check("data", wr_data_in, exp_data.size() > 0 ? exp_data.pop_front() : '0);
      check("last", wr_data_last, left == 1);
      if (left > 0) left--;
    end
    if (wr_req_en) begin
      req_cnt++;
      check("req_overlap", left, 0);
      check("req_expected", exp_len.size() > 0, 1'b1);
      if (exp_len.size() > 0) begin
        check("req_addr", wr_addr_in, exp_addr.pop_front());
        left = exp_len[0] + 1;
        check("req_len", wr_burst_len, exp_len.pop_front());
      end
    end
    if (cmd_done) done_cnt++;
    if (err_zero_len) err_cnt++;
  end
  task automatic expect_burst(input logic [AW-1:0] a, input int len);
    exp_addr.push_back(a);
    exp_len.push_back(len);
  endtask
  task automatic split(input logic [AW-1:0] a, input int beats);
    longint addr = longint'(a) & ~longint'(BYTES - 1);
    int rem = beats;
    while (rem > 0) begin
      int room, b;
      room = (4096 - int'(addr % 4096)) / BYTES;
      b = rem;
      if (b > MAXB) b = MAXB;
      if (b > room) b = room;
      expect_burst(addr[AW-1:0], b - 1);
      addr = (addr + longint'(b * BYTES)) % 64'h1_0000_0000;
      rem -= b;
    end
  endtask
  task automatic load(input logic [AW-1:0] a, input int beats, input bit use_model);
    for (int i = 0; i < beats; i++) begin
      logic [DW-1:0] d;
      d = {$urandom, $urandom, $urandom, $urandom};
      src_q.push_back(d);
      exp_data.push_back(d);
    end
    if (use_model) split(a, beats);
  endtask
  task automatic send(input logic [AW-1:0] a, input int beats);
    int t = 0;
    cmd_addr = a;
    cmd_beats = LW'(beats);
    cmd_valid = 1'b1;
    while (!cmd_ready && t < 200) begin
      @(negedge wr_clk);
      t++;
    end
    check("cmd_accept", cmd_ready, 1'b1);
    @(negedge wr_clk);
    cmd_valid = 1'b0;
  endtask
  task automatic wait_done(input int bound);
    int base = done_cnt, t = 0;
    exp_done++;
    while (done_cnt == base && t < bound) begin
      @(negedge wr_clk);
      t++;
    end
    check("done_seen", done_cnt - base, 1);
    check("src_consumed", src_idx, src_q.size());
    check("bursts_drained", exp_len.size(), 0);
    check("data_drained", exp_data.size(), 0);
    check("idle_after_done", busy, 1'b0);
    @(negedge wr_clk);
    check("done_once", done_cnt - base, 1);
  endtask
  initial begin
    int r0, e0, base, t;
    logic [AW-1:0] a;
    int beats;
    repeat (3) @(negedge wr_clk);
    check("rst_cmd_ready", cmd_ready, 1'b0);
    check("rst_s_ready", s_ready, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_pulses", {wr_req_en, wr_data_valid, wr_data_last, cmd_done, err_zero_len}, 5'b0);
    rst = 1'b0;
    @(negedge wr_clk);
    check("idle_cmd_ready", cmd_ready, 1'b1);
    r0 = req_cnt;
    load(32'h1000, 64, 1'b0);
    expect_burst(32'h1000, 63);
    send(32'h1000, 64);
    wait_done(2000);
    check("aligned_req_cnt", req_cnt - r0, 1);
    r0 = req_cnt;
    src_pct = 60;
    load(32'h1F8A, 20, 1'b0);
    expect_burst(32'h1F80, 7);
    expect_burst(32'h2000, 11);
    send(32'h1F8A, 20);
    wait_done(2000);
    check("page_split_req_cnt", req_cnt - r0, 2);
    r0 = req_cnt;
    load(32'h0, 150, 1'b0);
    expect_burst(32'h0, 63);
    expect_burst(32'h400, 63);
    expect_burst(32'h800, 21);
    send(32'h0, 150);
    wait_done(4000);
    check("max_split_req_cnt", req_cnt - r0, 3);
    load(32'hFFFF_FF80, 20, 1'b0);
    expect_burst(32'hFFFF_FF80, 7);
    expect_burst(32'h0, 11);
    send(32'hFFFF_FF80, 20);
    wait_done(2000);
    afull_force = 1'b1;
    src_pct = 50;
    r0 = req_cnt;
    load(32'h5000, 16, 1'b0);
    expect_burst(32'h5000, 15);
    send(32'h5000, 16);
    for (int i = 0; i < 10; i++) begin
      @(negedge wr_clk);
      check("bp_hold", wr_req_en, 1'b0);
    end
    check("bp_busy", busy, 1'b1);
    afull_force = 1'b0;
    @(negedge wr_clk);
    check("bp_release", wr_req_en, 1'b1);
    wait_done(2000);
    check("bp_req_cnt", req_cnt - r0, 1);
    r0 = req_cnt;
    e0 = err_cnt;
    send(32'h7000, 0);
    check("zero_err", err_zero_len, 1'b1);
    check("zero_busy", busy, 1'b0);
    @(negedge wr_clk);
    check("zero_err_pulse", err_zero_len, 1'b0);
    repeat (3) @(negedge wr_clk);
    check("zero_still_idle", busy, 1'b0);
    check("zero_no_req", req_cnt - r0, 0);
    check("zero_err_cnt", err_cnt - e0, 1);
    src_pct = 100;
    load(32'h6000, 64, 1'b0);
    expect_burst(32'h6000, 63);
    base = data_seen;
    send(32'h6000, 64);
    t = 0;
    while (data_seen - base < 5 && t < 500) begin
      @(negedge wr_clk);
      t++;
    end
    check("reset_reach5", data_seen - base >= 5, 1'b1);
    rst = 1'b1;
    @(negedge wr_clk);
    check("mid_rst_flags", {wr_req_en, wr_data_valid, wr_data_last, busy, cmd_done, err_zero_len, cmd_ready, s_ready}, 8'b0);
    check("mid_rst_data", wr_data_in, '0);
    check("mid_rst_addr", {wr_addr_in, wr_burst_len}, '0);
    @(negedge wr_clk);
    rst = 1'b0;
    src_q.delete();
    src_idx = 0;
    exp_addr.delete();
    exp_len.delete();
    exp_data.delete();
    left = 0;
    @(negedge wr_clk);
    check("post_rst_ready", cmd_ready, 1'b1);
    check("post_rst_busy", busy, 1'b0);
    load(32'h3000, 4, 1'b0);
    expect_burst(32'h3000, 3);
    send(32'h3000, 4);
    wait_done(500);
    afull_rand = 1'b1;
    for (int k = 0; k < 20; k++) begin
      a = $urandom;
      if ($urandom_range(0, 1) == 1) a[11:0] = 12'hF00 | 12'($urandom_range(0, 255));
      beats = $urandom_range(1, 300);
      src_pct = $urandom_range(30, 100);
      load(a, beats, 1'b1);
      send(a, beats);
      wait_done(beats * 20 + 300);
    end
    afull_rand = 1'b0;
    check("done_total", done_cnt, exp_done);
    check("err_total", err_cnt, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/wr_burst_ctrl.md
Name: wr_burst_ctrl

Overview:
- Write-side sequencer in the wr_clk domain, upstream of the write buffer.
- Accepts DMA write commands (start address plus beat count) and splits each into AXI-legal bursts.
  - Burst limit: at most MAX_BURST_LEN beats.
  - A burst never crosses a 4 KB page.
- For each burst it issues one command pulse (wr_req_en, wr_addr_in, wr_burst_len), then streams exactly that many beats from a valid/ready source onto wr_data_*, with wr_data_last on the final beat.
- Throttles on a buffer almost-full indication, so the buffer FIFOs never overflow.

Parameters:
- AXI_ADDR_WIDTH, 32, address width.
- AXI_DATA_WIDTH, 128, beat width; BYTES = AXI_DATA_WIDTH/8.
- MAX_BURST_LEN, 64, maximum beats per burst (1..256).
- LEN_WIDTH, 16, width of the command beat count.

Ports:
- wr_clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  block can accept a command.
- cmd_addr  in  AXI_ADDR_WIDTH  start byte address; low log2(BYTES) bits are ignored and treated as 0.
- cmd_beats  in  LEN_WIDTH  total beats; 0 is illegal.
- s_data  in  AXI_DATA_WIDTH  source data.
- s_valid  in  1  source beat valid.
- s_ready  out  1  source beat accepted when s_valid && s_ready.
- buf_afull  in  1  write buffer cannot take a full burst (cmd or data FIFO above threshold).
- wr_req_en  out  1  one-cycle burst command pulse.
- wr_addr_in  out  AXI_ADDR_WIDTH  burst address; valid with wr_req_en.
- wr_burst_len  out  8  beats-1; valid with wr_req_en.
- wr_data_in  out  AXI_DATA_WIDTH  beat data.
- wr_data_valid  out  1  beat valid.
- wr_data_last  out  1  last beat of the burst.
- busy  out  1  state != IDLE.
- cmd_done  out  1  one-cycle pulse after the final beat of a command.
- err_zero_len  out  1  one-cycle pulse when a command with cmd_beats==0 is accepted.

Behaviour:
- Reset (rst high at a clock edge): state=IDLE; all outputs 0, including cmd_ready and s_ready. Internal counters cleared. Reset mid-burst abandons the command with no further outputs. Integration resets the buffer in the same window.
- State machine, one-hot: IDLE, CALC, WAIT, DATA, NEXT.
- IDLE:
  - cmd_ready=1 (combinational from state).
  - On cmd_valid&&cmd_ready, latch cur_addr (aligned cmd_addr) and remain (cmd_beats).
  - If cmd_beats==0: pulse err_zero_len next cycle and stay in IDLE. Otherwise go to CALC.
- CALC (1 cycle): register burst_beats = min(remain, MAX_BURST_LEN, (4096 - cur_addr[11:0])/BYTES); go to WAIT.
- WAIT:
  - Hold while buf_afull=1.
  - When buf_afull=0, register wr_req_en=1, wr_addr_in=cur_addr, wr_burst_len=burst_beats-1; clear beat_cnt; go to DATA.
  - wr_req_en is high exactly one cycle, in the first DATA cycle.
- DATA:
  - s_ready=1 (combinational from state).
  - Each accepted beat produces, next cycle: wr_data_valid=1, wr_data_in=s_data, wr_data_last=(beat_cnt==burst_beats-1); beat_cnt increments.
  - Gaps in s_valid give wr_data_valid=0 cycles, with wr_data_in holding its last value.
  - On acceptance of the last beat go to NEXT. s_ready is 0 from NEXT onward, so no extra beat is taken.
- NEXT (1 cycle):
  - cur_addr += burst_beats*BYTES; remain -= burst_beats.
  - If remain==0: cmd_done pulses next cycle, go to IDLE. Otherwise go to CALC.
- Ordering: wr_req_en for burst k always precedes burst k's first wr_data_valid by at least 1 cycle; bursts never overlap.
- Minimum inter-burst gap: 3 cycles (NEXT, CALC, WAIT).
- Arithmetic:
  - Page math on cur_addr[11:0]; the boundary term is 4096/BYTES when the address is page-aligned.
  - cur_addr wraps modulo 2^AXI_ADDR_WIDTH.
  - remain is LEN_WIDTH bits and never underflows.
- buf_afull is sampled only in WAIT. Changes during DATA have no effect; the threshold must cover one full burst.

Decomposition:
- Package wr_dma_pkg:
  - State encodings.
  - PAGE_BYTES=4096.
  - Function beats_to_page(addr, BYTES).
- Sub-module wr_burst_calc: registered burst_beats from cur_addr, remain and MAX_BURST_LEN (the CALC stage). The top level holds the FSM, counters and output registers.

Test Plan:
- Single aligned burst: cmd_addr=0x1000, cmd_beats=64 -> one wr_req_en with addr 0x1000, len 63; 64 wr_data_valid; last on the 64th; cmd_done once.
- 4KB split: cmd_addr=0x1F80, cmd_beats=20 -> bursts (0x1F80, len 7) then (0x2000, len 11); data order preserved; exactly two last flags.
- Max-length split: cmd_addr=0x0, cmd_beats=150 -> bursts (0x0, 63), (0x400, 63), (0x800, 21).
- Backpressure: buf_afull=1 for 10 cycles while in WAIT -> no wr_req_en; wr_req_en the cycle after buf_afull falls. Randomized s_valid gaps -> beat count and last position unchanged.
- Zero length: cmd_beats=0 -> cmd accepted, err_zero_len pulse, no wr_req_en, busy stays 0.
- Reset mid-DATA after 5 of 64 beats -> next cycle all outputs 0, IDLE, cmd_ready=1 after rst falls; a following command at 0x3000 with 4 beats completes normally.
